serial_mod_checker: RTL and testbench

Parametrised serial divisibility checker: consumes a binary word one bit per valid cycle and tracks its running remainder modulo `DIVISOR`, reporting remainder and a divisible flag when the word ends. It generalises the fixed divide-by-5 serial FSM to any divisor, adds framing (`start`/`last`), a valid qualifier, bit counting with overflow, and an optional LSB-first mode. It sits on a serial input stream, upstream of any control logic that needs a per-word "multiple of N" decision.

---
 rtl/serial_mod_checker_if.sv | 30 +++
 rtl/serial_mod_checker.sv | 139 +++++++++++++
 tb/tb_serial_mod_checker.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mod_checker_if.sv
// serial_mod_checker_if: serial bit stream in, per-word remainder results out.
// The master side drives the framing and data bits; the slave side is the checker.
interface serial_mod_checker_if #(
  parameter int DIVISOR  = 5,
  parameter int MAX_BITS = 32
);
  localparam int REM_W = $clog2(DIVISOR);
  localparam int CNT_W = $clog2(MAX_BITS + 1);

  logic             start;
  logic             in_valid;
  logic             in;
  logic             last;
  logic [REM_W-1:0] rem;
  logic             divisible;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             ovf;

  modport master (
    output start, in_valid, in, last,
    input  rem, divisible, done, busy, bit_cnt, ovf
  );

  modport slave (
    input  start, in_valid, in, last,
    output rem, divisible, done, busy, bit_cnt, ovf
  );
endinterface

// File: rtl/serial_mod_checker.sv
// serial_mod_checker: tracks the remainder of a serially received binary word
// modulo DIVISOR and reports remainder / divisible with a one-cycle done pulse.
// Default build is MSB-first. Defining SERIAL_MOD_LSB_FIRST_EN switches to
// LSB-first reception, which adds a weight register holding 2^k mod DIVISOR.
// Remainder arithmetic uses a single conditional subtract per bit; operands
// never exceed 2*DIVISOR-1, so no divider is needed.
module serial_mod_checker #(
  parameter int DIVISOR  = 5,
  parameter int MAX_BITS = 32
) (
  input logic               clk,
  input logic               rst,
  serial_mod_checker_if.slave bus
);
  localparam int REM_W = $clog2(DIVISOR);
  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam logic [REM_W:0]   DIV_X   = (REM_W+1)'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             divisible_q;
  logic             done_q;
  logic             busy_q;

  // Word-start aware base values: start discards the previous word entirely.
  logic [REM_W-1:0] base_rem_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic             base_ovf_s;
  logic             go_s;

`ifdef SERIAL_MOD_LSB_FIRST_EN
  logic [REM_W-1:0] w_q;
  logic [REM_W-1:0] w_d;
  logic [REM_W-1:0] base_w_s;
`endif

  // Bring a value in [0, 2*DIVISOR-1] back into [0, DIVISOR-1].
  function automatic logic [REM_W-1:0] reduce(input logic [REM_W:0] t);
    logic [REM_W:0] r;
    if (t >= DIV_X) begin
      r = t - DIV_X;
    end else begin
      r = t;
    end
    return r[REM_W-1:0];
  endfunction

  // Next remainder, bit count and overflow for the bit presented this cycle.
  always_comb begin
    base_rem_s = bus.start ? {REM_W{1'b0}} : rem_q;
    base_cnt_s = bus.start ? {CNT_W{1'b0}} : bit_cnt_q;
    base_ovf_s = bus.start ? 1'b0 : ovf_q;
    go_s       = bus.start || (state_q == ACCUM);
    rem_d      = base_rem_s;
    bit_cnt_d  = base_cnt_s;
    ovf_d      = base_ovf_s;
`ifdef SERIAL_MOD_LSB_FIRST_EN
    base_w_s   = bus.start ? REM_W'(1'b1) : w_q;
    w_d        = base_w_s;
`endif
    if (bus.in_valid) begin
`ifdef SERIAL_MOD_LSB_FIRST_EN
      rem_d = reduce({1'b0, base_rem_s} +
                     (bus.in ? {1'b0, base_w_s} : {(REM_W+1){1'b0}}));
      w_d   = reduce({base_w_s, 1'b0});
`else
      rem_d = reduce({base_rem_s, bus.in});
`endif
      if (base_cnt_s == CNT_MAX) begin
        bit_cnt_d = CNT_MAX;
        ovf_d     = 1'b1;
      end else begin
        bit_cnt_d = base_cnt_s + CNT_W'(1'b1);
        ovf_d     = base_ovf_s;
      end
    end else begin
      bit_cnt_d = base_cnt_s;
      ovf_d     = base_ovf_s;
    end
  end

  // Word framing FSM with registered result outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= {REM_W{1'b0}};
      bit_cnt_q   <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      divisible_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_MOD_LSB_FIRST_EN
      w_q         <= {REM_W{1'b0}};
`endif
    end else if (go_s) begin
      rem_q     <= rem_d;
      bit_cnt_q <= bit_cnt_d;
      ovf_q     <= ovf_d;
`ifdef SERIAL_MOD_LSB_FIRST_EN
      w_q       <= w_d;
`endif
      if (bus.in_valid && bus.last) begin
        state_q     <= DONE;
        done_q      <= 1'b1;
        busy_q      <= 1'b0;
        divisible_q <= (rem_d == {REM_W{1'b0}});
      end else begin
        state_q     <= ACCUM;
        done_q      <= 1'b0;
        busy_q      <= 1'b1;
        divisible_q <= 1'b0;
      end
    end else begin
      // IDLE or the single DONE cycle without start: results hold.
      state_q <= IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end
  end

  assign bus.rem       = rem_q;
  assign bus.divisible = divisible_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_mod_checker.sv
// tb_serial_mod_checker: three checkers (DIVISOR/MAX_BITS = 5/32, 3/32, 7/4)
// share one directed stimulus stream. A reference model keeps the full word
// value and pushes expected results when a last bit is driven; a monitor pops
// and compares on every done pulse.
module tb_serial_mod_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_mod_checker_if #(.DIVISOR(5), .MAX_BITS(32)) if5 ();
  serial_mod_checker_if #(.DIVISOR(3), .MAX_BITS(32)) if3 ();
  serial_mod_checker_if #(.DIVISOR(7), .MAX_BITS(4))  if7 ();

  serial_mod_checker #(.DIVISOR(5), .MAX_BITS(32)) u5 (.clk(clk), .rst(rst), .bus(if5.slave));
  serial_mod_checker #(.DIVISOR(3), .MAX_BITS(32)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  serial_mod_checker #(.DIVISOR(7), .MAX_BITS(4))  u7 (.clk(clk), .rst(rst), .bus(if7.slave));

  typedef struct {
    int rem;
    bit dv;
    int cnt;
    bit ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned val_a[3];
  int  div_a[3];
  int  max_a[3];
  int  cnt_a[3];
  bit  ovf_a[3];
  int  nbits;
  bit  in_word;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_done(input int k, input int rem, input bit dv, input int cnt, input bit ovf);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      default: have = 1'b0;
    endcase
    n_tests++;
    assert (have === 1'b1) else begin
      n_fail++;
      $error("FAIL sb_unexpected_done dut%0d observed=1 expected=0", k);
    end
    if (have) begin
      chk($sformatf("sb_rem_dut%0d", k), rem, e.rem);
      chk($sformatf("sb_divisible_dut%0d", k), int'(dv), int'(e.dv));
      chk($sformatf("sb_bit_cnt_dut%0d", k), cnt, e.cnt);
      chk($sformatf("sb_ovf_dut%0d", k), int'(ovf), int'(e.ovf));
    end
  endtask

  // Scoreboard monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (if5.done) check_done(0, int'(if5.rem), if5.divisible, int'(if5.bit_cnt), if5.ovf);
    if (if3.done) check_done(1, int'(if3.rem), if3.divisible, int'(if3.bit_cnt), if3.ovf);
    if (if7.done) check_done(2, int'(if7.rem), if7.divisible, int'(if7.bit_cnt), if7.ovf);
  end

  task automatic drive(input bit st, input bit v, input bit b, input bit l);
    if5.start = st; if5.in_valid = v; if5.in = b; if5.last = l;
    if3.start = st; if3.in_valid = v; if3.in = b; if3.last = l;
    if7.start = st; if7.in_valid = v; if7.in = b; if7.last = l;
  endtask

  // One cycle of stimulus plus the reference model update.
  task automatic step(input bit r, input bit st, input bit v, input bit b, input bit l);
    exp_t e;
    @(negedge clk);
    rst = r;
    drive(st, v, b, l);
    if (r) begin
      in_word = 1'b0;
    end else begin
      if (st) begin
        in_word = 1'b1;
        nbits   = 0;
        for (int k = 0; k < 3; k++) begin
          val_a[k] = 64'd0; cnt_a[k] = 0; ovf_a[k] = 1'b0;
        end
      end
      if (v && in_word) begin
        for (int k = 0; k < 3; k++) begin
`ifdef SERIAL_MOD_LSB_FIRST_EN
          if (b) val_a[k] = val_a[k] + (64'd1 << nbits);
`else
          val_a[k] = val_a[k] * 64'd2 + (b ? 64'd1 : 64'd0);
`endif
          if (cnt_a[k] == max_a[k]) ovf_a[k] = 1'b1;
          else cnt_a[k] = cnt_a[k] + 1;
        end
        nbits++;
        if (l) begin
          for (int k = 0; k < 3; k++) begin
            e.rem = int'(val_a[k] % longint'(div_a[k]));
            e.dv  = (e.rem == 0);
            e.cnt = cnt_a[k];
            e.ovf = ovf_a[k];
            if (k == 0) q0.push_back(e);
            else if (k == 1) q1.push_back(e);
            else q2.push_back(e);
          end
          in_word = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rem5"},  int'(if5.rem), 0);
    chk({tag, "_div5"},  int'(if5.divisible), 0);
    chk({tag, "_done5"}, int'(if5.done), 0);
    chk({tag, "_busy5"}, int'(if5.busy), 0);
    chk({tag, "_cnt5"},  int'(if5.bit_cnt), 0);
    chk({tag, "_ovf5"},  int'(if5.ovf), 0);
    chk({tag, "_rem7"},  int'(if7.rem), 0);
    chk({tag, "_cnt7"},  int'(if7.bit_cnt), 0);
    chk({tag, "_ovf7"},  int'(if7.ovf), 0);
    chk({tag, "_busy7"}, int'(if7.busy), 0);
  endtask

  initial begin
    div_a = '{5, 3, 7};
    max_a = '{32, 32, 4};
    nbits = 0;
    in_word = 1'b0;
    for (int k = 0; k < 3; k++) begin
      val_a[k] = 64'd0; cnt_a[k] = 0; ovf_a[k] = 1'b0;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_all_zero("reset");

    // Word 1,0,1,0,0 with last on the fifth bit
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("t1_busy_accum", int'(if5.busy), 1);
    chk("t1_cnt_after_start", int'(if5.bit_cnt), 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("t1_busy_in_done", int'(if5.busy), 0);
    chk("t1_done_pulse", int'(if5.done), 1);
    step(0, 0, 0, 0, 0);
    chk("t1_done_cleared", int'(if5.done), 0);
    chk("t1_cnt_hold", int'(if5.bit_cnt), 5);
    chk("t1_div_hold", int'(if5.divisible), (val_a[0] % 64'd5 == 64'd0) ? 1 : 0);

    // Word 1,1,1 then a one-bit word started during the DONE cycle
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    step(0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("t2_b2b_done", int'(if5.done), 1);
    chk("t2_b2b_cnt", int'(if5.bit_cnt), 1);
    // Data without start while idle is ignored
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("t2_idle_ignore_done", int'(if5.done), 0);
    chk("t2_idle_ignore_rem", int'(if5.rem), 0);
    chk("t2_idle_ignore_cnt", int'(if5.bit_cnt), 1);

    // Restart mid-word: aborted word 1,0,1 gives no done; then 1,1,0 with gaps
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Six ones: overflow on the MAX_BITS=4 instance, then start clears it
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_ovf7_hold", int'(if7.ovf), 1);
    chk("t4_cnt7_sat", int'(if7.bit_cnt), 4);
    chk("t4_cnt5", int'(if5.bit_cnt), 6);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_ovf7_cleared", int'(if7.ovf), 0);
    chk("t4_cnt7_cleared", int'(if7.bit_cnt), 0);
    chk("t4_busy7", int'(if7.busy), 1);

    // Reset mid-word with valid gaps
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_mid_rem5", int'(if5.rem), int'(val_a[0] % 64'd5));
    chk("t5_mid_rem3", int'(if3.rem), int'(val_a[1] % 64'd3));
    chk("t5_mid_cnt5", int'(if5.bit_cnt), 3);
    step(1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    chk_all_zero("t5_rst");
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    chk_all_zero("t5_rst_start");

    // Bits 0,0,1,0,1 then back-to-back 1,1,0,1
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1);
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("t6_rem5", int'(if5.rem), int'(val_a[0] % 64'd5));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Every expected result was produced exactly once
    chk("sb_drain_dut0", q0.size(), 0);
    chk("sb_drain_dut1", q1.size(), 0);
    chk("sb_drain_dut2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
